// File: rtl/bitwise_adder_24bit.sv
// Unsigned 24-bit ripple-carry adder with combinational and registered result.
// Optional signed-overflow outputs are built when BITWISE_ADDER_OVF_EN is defined.
module bitwise_adder_24bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic        carry_in,
  output logic [23:0] sum,
  output logic        carry_out,
  output logic [23:0] sum_q,
  output logic        carry_out_q
`ifdef BITWISE_ADDER_OVF_EN
  ,
  output logic        overflow,
  output logic        overflow_q
`endif
);

  logic [24:0] c;
  logic [23:0] s;
  logic [23:0] sum_d;
  logic        carry_out_d;

  // One full-adder cell per bit; the loop unrolls into a 24-stage carry ripple.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = carry_in;
    for (int i = 0; i < 24; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign sum       = s;
  assign carry_out = c[24];

  always_comb begin
    sum_d       = sum;
    carry_out_d = carry_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= 24'h000000;
      carry_out_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
    end
  end

`ifdef BITWISE_ADDER_OVF_EN
  logic overflow_d;

  // Carry into the sign bit differing from carry out of it means signed overflow.
  assign overflow = c[23] ^ c[24];

  always_comb begin
    overflow_d = overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end
`endif

endmodule

// File: tb/tb_bitwise_adder_24bit.sv
// Self-checking bench for bitwise_adder_24bit: directed vectors, async reset,
// mid-stream reset and a random stream scored through an expected-result queue.
module tb_bitwise_adder_24bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] a;
  logic [23:0] b;
  logic        carry_in;
  logic [23:0] sum;
  logic        carry_out;
  logic [23:0] sum_q;
  logic        carry_out_q;
  logic        ovf_c;
  logic        ovf_r;

  int total = 0;
  int bad   = 0;

  logic [25:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

`ifdef BITWISE_ADDER_OVF_EN
  logic overflow;
  logic overflow_q;
  assign ovf_c = overflow;
  assign ovf_r = overflow_q;
`else
  assign ovf_c = 1'b0;
  assign ovf_r = 1'b0;
`endif

  bitwise_adder_24bit dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .carry_in    (carry_in),
    .sum         (sum),
    .carry_out   (carry_out),
    .sum_q       (sum_q),
    .carry_out_q (carry_out_q)
`ifdef BITWISE_ADDER_OVF_EN
    ,
    .overflow    (overflow),
    .overflow_q  (overflow_q)
`endif
  );

  task automatic check_eq(input string tag, input logic [25:0] got, input logic [25:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, carry_out, sum}; overflow is zero when the feature is absent.
  function automatic logic [25:0] model(input logic [23:0] ma, input logic [23:0] mb,
                                        input logic mci);
    logic [24:0] t;
    logic        v;
    t = {1'b0, ma} + {1'b0, mb} + {24'd0, mci};
    v = (ma[23] == mb[23]) && (t[23] != ma[23]);
`ifndef BITWISE_ADDER_OVF_EN
    v = 1'b0;
`endif
    return {v, t};
  endfunction

  function automatic logic [25:0] comb_obs();
    return {ovf_c, carry_out, sum};
  endfunction

  function automatic logic [25:0] reg_obs();
    return {ovf_r, carry_out_q, sum_q};
  endfunction

  // driver: apply inputs at negedge, check comb, queue the expected registered value
  task automatic drive(input string tag, input logic [23:0] da, input logic [23:0] db,
                       input logic dci);
    @(negedge clk);
    a        = da;
    b        = db;
    carry_in = dci;
    #1;
    check_eq({tag, "_comb"}, comb_obs(), model(da, db, dci));
    exp_q.push_back(model(da, db, dci));
  endtask

  // scoreboard: after the capturing edge, pop and compare the registered output
  task automatic score(input string tag);
    logic [25:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 26'h1, 26'h0);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_reg"}, reg_obs(), e);
    end
  endtask

  task automatic step(input string tag, input logic [23:0] da, input logic [23:0] db,
                      input logic dci);
    drive(tag, da, db, dci);
    score(tag);
  endtask

  logic [23:0] va  [5];
  logic [23:0] vb  [5];
  logic        vci [5];

  initial begin
    va[0] = 24'h000001; vb[0] = 24'h000001; vci[0] = 1'b0;
    va[1] = 24'hFFFFFF; vb[1] = 24'h000001; vci[1] = 1'b0;
    va[2] = 24'h7FFFFF; vb[2] = 24'h000001; vci[2] = 1'b1;
    va[3] = 24'hFFFFFF; vb[3] = 24'hFFFFFF; vci[3] = 1'b1;
    va[4] = 24'hAAAAAA; vb[4] = 24'h555555; vci[4] = 1'b1;

    rst      = 1'b1;
    a        = 24'h000001;
    b        = 24'h000001;
    carry_in = 1'b0;
    #1;
    check_eq("rst_async", reg_obs(), 26'h0);
    check_eq("rst_comb_live", comb_obs(), {2'b00, 24'h000002});

    @(negedge clk);
    rst = 1'b0;

    // directed vectors with hand-computed expectations alongside the model
    step("plus1", va[0], vb[0], vci[0]);
    check_eq("plus1_const", comb_obs(), {2'b00, 24'h000002});
    step("wrap", va[1], vb[1], vci[1]);
    check_eq("wrap_const", {1'b0, carry_out, sum}, {2'b01, 24'h000000});
    step("sign", va[2], vb[2], vci[2]);
    check_eq("sign_const", {1'b0, carry_out, sum}, {2'b00, 24'h800001});
    step("allprop", va[3], vb[3], vci[3]);
    check_eq("allprop_const", {1'b0, carry_out, sum}, {2'b01, 24'hFFFFFF});
    step("alt", va[4], vb[4], vci[4]);
    check_eq("alt_const", {1'b0, carry_out, sum}, {2'b01, 24'h000000});

    step("regstage", 24'h123456, 24'h654321, 1'b0);
    check_eq("regstage_const", {1'b0, carry_out_q, sum_q}, {2'b00, 24'h777777});

    // reset mid-stream: registers clear at once, comb path keeps tracking
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_reg", reg_obs(), 26'h0);
    check_eq("midrst_comb", {1'b0, carry_out, sum}, {2'b00, 24'h777777});
    @(posedge clk);
    #1;
    check_eq("midrst_hold", reg_obs(), 26'h0);
    @(negedge clk);
    rst = 1'b0;

    // first capture after release
    step("post_rst", 24'h000010, 24'h000020, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      step("rand", 24'($urandom_range(24'hFFFFFF, 0)), 24'($urandom_range(24'hFFFFFF, 0)),
           1'($urandom_range(1, 0)));
    end

    check_eq("queue_drained", 26'(exp_q.size()), 26'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
